// File: rtl/coin_pkg.sv
// -----------------------------------------------------------------------------
// coin_pkg
// Shared definitions for the coin acceptor and the downstream vending FSM so
// both sides agree on the coin codes.
//   coin_code_e  : 2-bit coin code carried on the `coin` bus (never 2'b11)
//   coin_state_e : 3-bit acceptance FSM state encoding
//   STATS_W      : width of the optional insertion statistics counters
// -----------------------------------------------------------------------------
package coin_pkg;

    typedef enum logic [1:0] {
        COIN_NONE = 2'b00,
        COIN_05   = 2'b01,
        COIN_10   = 2'b10
    } coin_code_e;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ACCEPT   = 3'd1,
        ST_REJECT   = 3'd2,
        ST_WAIT_REL = 3'd3,
        ST_STUCK    = 3'd4
    } coin_state_e;

    localparam int STATS_W = 8;

endpackage : coin_pkg

// File: rtl/coin_sense_filter.sv
// -----------------------------------------------------------------------------
// coin_sense_filter
// Two-flop synchroniser followed by a debounce filter for one raw coin sensor.
// The filtered output only changes after the synchronised input has disagreed
// with it for DEB_CYCLES consecutive cycles.
//   clk   in  : system clock
//   rstn  in  : asynchronous active-low reset
//   sense in  : raw, asynchronous, possibly bouncing sensor
//   filt  out : synchronised, debounced sensor level
// Parameter DEB_CYCLES (>= 2): stable cycles needed before `filt` toggles.
// -----------------------------------------------------------------------------
module coin_sense_filter #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic sense,
    output logic filt
);

    localparam int CW = $clog2(DEB_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of the others; blocking here would collapse the synchroniser.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            filt  <= 1'b0;
        end else begin
            sync1 <= sense;
            sync2 <= sync1;
            if (sync2 == filt) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // Disagreement has now lasted DEB_CYCLES cycles: accept it.
                filt <= ~filt;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CNT_ONE;
            end
        end
    end

endmodule : coin_sense_filter

// File: rtl/coin_acceptor.sv
// -----------------------------------------------------------------------------
// coin_acceptor
// Turns the two raw coin-slot sensors into a clean one-cycle `coin` code for the
// vending FSM. Each sensor is synchronised and debounced, then an acceptance FSM
// accepts single coins, rejects illegal or locked-out insertions and flags a
// sensor that stays high too long.
//   clk       in  : system clock
//   rstn      in  : asynchronous active-low reset
//   sense_05  in  : raw 0.5-yuan sensor
//   sense_10  in  : raw 1-yuan sensor
//   lock      in  : downstream busy; coins seen while high are rejected
//   coin      out : one-cycle coin code (00 none, 01 0.5 yuan, 10 1 yuan)
//   reject    out : one-cycle pulse opening the return flap
//   err       out : high while a sensor is considered stuck
// Optional macro COIN_ACCEPTOR_STATS_EN adds saturating 8-bit counters:
//   cnt_05, cnt_10 out : accepted coins of each kind
//   cnt_rej        out : rejected insertions
// -----------------------------------------------------------------------------
module coin_acceptor
    import coin_pkg::*;
#(
    parameter int DEB_CYCLES   = 4,
    parameter int STUCK_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               sense_05,
    input  logic               sense_10,
    input  logic               lock,
    output logic [1:0]         coin,
    output logic               reject,
    output logic               err
`ifdef COIN_ACCEPTOR_STATS_EN
    ,
    output logic [STATS_W-1:0] cnt_05,
    output logic [STATS_W-1:0] cnt_10,
    output logic [STATS_W-1:0] cnt_rej
`endif
);

    localparam int SW = $clog2(STUCK_CYCLES) + 1;
    localparam logic [SW-1:0] STUCK_LAST = SW'(STUCK_CYCLES - 1);
    localparam logic [SW-1:0] STUCK_MAX  = SW'(STUCK_CYCLES);
    localparam logic [SW-1:0] STUCK_ONE  = SW'(1);

    logic        f05;
    logic        f10;
    coin_state_e state;
    coin_state_e state_next;
    coin_code_e  code_q;
    logic [SW-1:0] stuck_cnt;

    coin_sense_filter #(.DEB_CYCLES(DEB_CYCLES)) u_filt_05 (
        .clk   (clk),
        .rstn  (rstn),
        .sense (sense_05),
        .filt  (f05)
    );

    coin_sense_filter #(.DEB_CYCLES(DEB_CYCLES)) u_filt_10 (
        .clk   (clk),
        .rstn  (rstn),
        .sense (sense_10),
        .filt  (f10)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (f05 && f10) begin
                    state_next = ST_REJECT;
                end else if (f05 ^ f10) begin
                    state_next = lock ? ST_REJECT : ST_ACCEPT;
                end
            end
            ST_ACCEPT,
            ST_REJECT: state_next = ST_WAIT_REL;
            ST_WAIT_REL: begin
                // Release wins over the stuck timeout on the same cycle.
                if (!f05 && !f10) begin
                    state_next = ST_IDLE;
                end else if (stuck_cnt == STUCK_LAST) begin
                    state_next = ST_STUCK;
                end
            end
            ST_STUCK: begin
                if (!f05 && !f10) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Code is captured only on the IDLE->ACCEPT step, so a second sensor
    // appearing later cannot alter the emitted coin.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            code_q <= COIN_NONE;
        end else if (state == ST_IDLE && state_next == ST_ACCEPT) begin
            code_q <= f05 ? COIN_05 : COIN_10;
        end
    end

    // Counts cycles spent in WAIT_REL; frozen in STUCK, cleared elsewhere.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stuck_cnt <= '0;
        end else begin
            case (state)
                ST_WAIT_REL: begin
                    if (stuck_cnt != STUCK_MAX) begin
                        stuck_cnt <= stuck_cnt + STUCK_ONE;
                    end
                end
                ST_STUCK: stuck_cnt <= stuck_cnt;
                default:  stuck_cnt <= '0;
            endcase
        end
    end

    // Moore outputs: decoded from registered state only.
    always_comb begin
        coin   = COIN_NONE;
        reject = 1'b0;
        err    = 1'b0;
        case (state)
            ST_ACCEPT: coin   = code_q;
            ST_REJECT: reject = 1'b1;
            ST_STUCK:  err    = 1'b1;
            default: ;
        endcase
    end

`ifdef COIN_ACCEPTOR_STATS_EN
    localparam logic [STATS_W-1:0] STAT_MAX = '1;
    localparam logic [STATS_W-1:0] STAT_ONE = STATS_W'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_05  <= '0;
            cnt_10  <= '0;
            cnt_rej <= '0;
        end else begin
            if (state == ST_ACCEPT && code_q == COIN_05 && cnt_05 != STAT_MAX) begin
                cnt_05 <= cnt_05 + STAT_ONE;
            end
            if (state == ST_ACCEPT && code_q == COIN_10 && cnt_10 != STAT_MAX) begin
                cnt_10 <= cnt_10 + STAT_ONE;
            end
            if (state == ST_REJECT && cnt_rej != STAT_MAX) begin
                cnt_rej <= cnt_rej + STAT_ONE;
            end
        end
    end
`endif

endmodule : coin_acceptor

// File: tb/tb_coin_acceptor.sv
// -----------------------------------------------------------------------------
// tb_coin_acceptor
// Directed stimulus for coin_acceptor. A behavioural model tracks what the
// outputs must be from the raw sensor history; a compare process checks the DUT
// against it every cycle, and directed checks pin pulse timing with literals.
// Honours COIN_ACCEPTOR_STATS_EN when defined.
// -----------------------------------------------------------------------------
module tb_coin_acceptor;

    localparam int DEB   = 4;
    localparam int STUCK = 1024;

    logic       clk      = 1'b0;
    logic       rstn     = 1'b0;
    logic       sense_05 = 1'b0;
    logic       sense_10 = 1'b0;
    logic       lock     = 1'b0;
    logic [1:0] coin;
    logic       reject;
    logic       err;
`ifdef COIN_ACCEPTOR_STATS_EN
    logic [7:0] cnt_05;
    logic [7:0] cnt_10;
    logic [7:0] cnt_rej;
`endif

    always #5 clk = ~clk;

    coin_acceptor #(.DEB_CYCLES(DEB), .STUCK_CYCLES(STUCK)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .sense_05 (sense_05),
        .sense_10 (sense_10),
        .lock     (lock),
        .coin     (coin),
        .reject   (reject),
        .err      (err)
`ifdef COIN_ACCEPTOR_STATS_EN
        ,
        .cnt_05   (cnt_05),
        .cnt_10   (cnt_10),
        .cnt_rej  (cnt_rej)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural model ----------------
    bit         h05[$];
    bit         h10[$];
    bit         mf05 = 1'b0;
    bit         mf10 = 1'b0;
    logic [1:0] m_coin  = 2'b00;
    bit         m_rej   = 1'b0;
    bit         m_err   = 1'b0;
    bit         m_armed = 1'b1;
    int         m_wait  = 0;
`ifdef COIN_ACCEPTOR_STATS_EN
    int         m_n05  = 0;
    int         m_n10  = 0;
    int         m_nrej = 0;
`endif

    // Filtered level flips once the last DEB synchronised samples (raw samples
    // from 2..DEB+1 edges ago) all disagree with it. Missing history reads 0.
    function automatic bit filt_next(input bit f, input bit h[$]);
        for (int j = 2; j <= DEB + 1; j++) begin
            bit s;
            s = (h.size() - j >= 0) ? h[h.size() - j] : 1'b0;
            if (s == f) return f;
        end
        return !f;
    endfunction

    initial forever begin
        @(posedge clk or negedge rstn);
        if (!rstn) begin
            h05.delete();
            h10.delete();
            mf05 = 0; mf10 = 0;
            m_coin = 2'b00; m_rej = 0; m_err = 0; m_armed = 1; m_wait = 0;
`ifdef COIN_ACCEPTOR_STATS_EN
            m_n05 = 0; m_n10 = 0; m_nrej = 0;
`endif
        end else begin
            if (m_coin != 2'b00 || m_rej) begin
`ifdef COIN_ACCEPTOR_STATS_EN
                if (m_coin == 2'b01 && m_n05 < 255) m_n05++;
                if (m_coin == 2'b10 && m_n10 < 255) m_n10++;
                if (m_rej && m_nrej < 255) m_nrej++;
`endif
                m_coin = 2'b00;
                m_rej  = 0;
                m_wait = 0;
            end else if (m_armed) begin
                if (mf05 || mf10) begin
                    m_armed = 0;
                    if ((mf05 && mf10) || lock) m_rej = 1;
                    else m_coin = mf05 ? 2'b01 : 2'b10;
                end
            end else if (!mf05 && !mf10) begin
                m_armed = 1;
                m_err   = 0;
            end else if (!m_err) begin
                m_wait++;
                if (m_wait == STUCK) m_err = 1;
            end
            mf05 = filt_next(mf05, h05);
            mf10 = filt_next(mf10, h10);
            h05.push_back(sense_05);
            h10.push_back(sense_10);
            if (h05.size() > DEB + 2) void'(h05.pop_front());
            if (h10.size() > DEB + 2) void'(h10.pop_front());
        end
    end

    // ---------------- compare + event monitor ----------------
    int         n_coin = 0, n_rej = 0, n_err_rise = 0;
    int         coin_edge = 0, rej_edge = 0, err_rise = 0, err_fall = 0;
    logic [1:0] last_code = 2'b00;
    logic       err_prev = 1'b0;

    initial forever begin
        @(negedge clk);
        if (rstn) begin
            check("coin", coin, m_coin);
            check("reject", reject, m_rej);
            check("err", err, m_err);
`ifdef COIN_ACCEPTOR_STATS_EN
            check("cnt_05", cnt_05, m_n05);
            check("cnt_10", cnt_10, m_n10);
            check("cnt_rej", cnt_rej, m_nrej);
`endif
        end
        if (coin != 2'b00) begin n_coin++; coin_edge = cyc; last_code = coin; end
        if (reject) begin n_rej++; rej_edge = cyc; end
        if (err && !err_prev) begin n_err_rise++; err_rise = cyc; end
        if (!err && err_prev) err_fall = cyc;
        err_prev = err;
    end

    task automatic clear_mon();
        n_coin = 0; n_rej = 0; n_err_rise = 0;
        coin_edge = 0; rej_edge = 0; err_rise = 0; err_fall = 0;
        last_code = 2'b00;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    int rise;

    initial begin
        tick(3);
        check("reset_coin", coin, 2'b00);
        check("reset_reject", reject, 1'b0);
        check("reset_err", err, 1'b0);
        rstn = 1'b1;
        tick(2);

        // Clean 0.5-yuan pulse: coin at edge 7 after the rise.
        clear_mon();
        rise = cyc + 1;
        sense_05 = 1'b1; tick(20); sense_05 = 1'b0; tick(15);
        check("t1_coins", n_coin, 1);
        check("t1_code", last_code, 2'b01);
        check("t1_edge", coin_edge - rise + 1, 7);
        check("t1_rej", n_rej, 0);

        // Bouncing 1-yuan sensor: timed from the last stable rise.
        clear_mon();
        sense_10 = 1'b1; tick(1); sense_10 = 1'b0; tick(1);
        rise = cyc + 1;
        sense_10 = 1'b1; tick(20); sense_10 = 1'b0; tick(15);
        check("t2_coins", n_coin, 1);
        check("t2_code", last_code, 2'b10);
        check("t2_edge", coin_edge - rise + 1, 7);
        check("t2_rej", n_rej, 0);

        // Both sensors together: single reject, no coin.
        clear_mon();
        rise = cyc + 1;
        sense_05 = 1'b1; sense_10 = 1'b1; tick(20);
        sense_05 = 1'b0; sense_10 = 1'b0; tick(15);
        check("t3_rej", n_rej, 1);
        check("t3_rej_edge", rej_edge - rise + 1, 7);
        check("t3_coins", n_coin, 0);

        // Locked: single reject, no coin.
        clear_mon();
        lock = 1'b1;
        sense_05 = 1'b1; tick(20); sense_05 = 1'b0; tick(15);
        lock = 1'b0;
        check("t4_rej", n_rej, 1);
        check("t4_coins", n_coin, 0);

        // Lock rising during the ACCEPT cycle does not cancel the coin.
        clear_mon();
        rise = cyc + 1;
        sense_05 = 1'b1; tick(7); lock = 1'b1; tick(13);
        sense_05 = 1'b0; tick(15); lock = 1'b0;
        check("t4b_coins", n_coin, 1);
        check("t4b_rej", n_rej, 0);

        // Stuck 1-yuan sensor held 1100 cycles.
        clear_mon();
        rise = cyc + 1;
        sense_10 = 1'b1; tick(1100); sense_10 = 1'b0; tick(15);
        check("t5_coins", n_coin, 1);
        check("t5_code", last_code, 2'b10);
        check("t5_err_rises", n_err_rise, 1);
        check("t5_err_rise_edge", err_rise - rise + 1, 8 + STUCK);
        check("t5_err_fall_edge", err_fall - rise + 1, 1100 + DEB + 3);

        // Reset after f05 has risen but before ACCEPT: nothing emitted.
        rise = cyc + 1;
        sense_05 = 1'b1; tick(6);
        rstn = 1'b0;
        #1;
        check("t6_coin_in_reset", coin, 2'b00);
        check("t6_rej_in_reset", reject, 1'b0);
        check("t6_err_in_reset", err, 1'b0);
        clear_mon();
        sense_05 = 1'b0; tick(2);
        rstn = 1'b1; tick(20);
        check("t6_coins", n_coin, 0);
        check("t6_rej", n_rej, 0);

`ifdef COIN_ACCEPTOR_STATS_EN
        check("stats_05_reset", cnt_05, 0);
        check("stats_10_reset", cnt_10, 0);
        check("stats_rej_reset", cnt_rej, 0);
        clear_mon();
        for (int i = 0; i < 300; i++) begin
            sense_05 = 1'b1; tick(8); sense_05 = 1'b0; tick(10);
        end
        check("stats_coins", n_coin, 300);
        check("stats_05_sat", cnt_05, 255);
        check("stats_10_idle", cnt_10, 0);
        check("stats_rej_idle", cnt_rej, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_coin_acceptor
